// File: rtl/max5_frame_ctrl.sv
// max5_frame_ctrl: collects NUM_SAMP samples, drives the packed frame to an
// external max-finder, and returns the max and its lowest index per frame.
// Ports:
//   clk, rst_n (async active-low), flush (sync abort)
//   in_valid/in_data/in_ready     sample stream in
//   fmax_val -> finder, fmax_max <- finder
//   out_valid/out_ready/out_max/out_idx  result stream out
//   frame_cnt                      delivered-frame counter
module max5_frame_ctrl #(
  parameter int DW       = 4,
  parameter int NUM_SAMP = 5,
  parameter int FCW      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic [NUM_SAMP*DW-1:0] fmax_val,
  input  logic [DW-1:0]          fmax_max,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_max,
  output logic [2:0]             out_idx,
  output logic [FCW-1:0]         frame_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [2:0] LAST = 3'(NUM_SAMP - 1);

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [DW-1:0]  slot_q [NUM_SAMP];
  logic           ov_q, ov_d;
  logic [DW-1:0]  max_q;
  logic [2:0]     idx_q, idx_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           calc_en;
  logic           accept;
  logic           found;

  // flush blocks acceptance even though in_ready may read 1
  assign accept   = (state_q == COLLECT) & in_valid & ~flush;
  assign in_ready = (state_q == COLLECT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    fc_d    = fc_q;
    calc_en = 1'b0;
    if (flush) begin
      state_d = COLLECT;
      cnt_d   = 3'd0;
      ov_d    = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              cnt_d   = 3'd0;
              state_d = CALC;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        CALC: begin
          calc_en = 1'b1;
          ov_d    = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            ov_d    = 1'b0;
            fc_d    = fc_q + 1'b1;
            state_d = COLLECT;
          end
        end
        default: begin
          state_d = COLLECT;
          cnt_d   = 3'd0;
          ov_d    = 1'b0;
        end
      endcase
    end
  end

  // Scan high to low so the lowest matching slot wins.
  // No match leaves the last index as a fault marker.
  always_comb begin
    idx_d = LAST;
    found = 1'b0;
    for (int i = NUM_SAMP - 1; i >= 0; i--) begin
      if (slot_q[i] == fmax_max) begin
        idx_d = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    fmax_val = '0;
    for (int i = 0; i < NUM_SAMP; i++) begin
      fmax_val[(NUM_SAMP-i)*DW-1 -: DW] = slot_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= 3'd0;
      ov_q    <= 1'b0;
      fc_q    <= '0;
      max_q   <= '0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      fc_q    <= fc_d;
      if (calc_en) begin
        max_q <= fmax_max;
        idx_q <= idx_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SAMP; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SAMP; i++) begin
        if (accept && (cnt_q == 3'(i))) begin
          slot_q[i] <= in_data;
        end
      end
    end
  end

  assign out_valid = ov_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign frame_cnt = fc_q;

`ifndef SYNTHESIS
  // A finder returning a value absent from the frame is a hardware fault.
  always @(posedge clk) begin
    if (rst_n && (state_q == CALC) && !flush) begin
      assert (found)
        else $error("max5_frame_ctrl: finder max not in frame");
    end
  end
`endif

endmodule
